// File: rtl/adv7180_cfg_pkg.sv
// Shared types and the power-up register table for the ADV7180 configuration master.
`timescale 1ns/1ps
package adv7180_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // {sub-address, data}, written in this order
  localparam logic [15:0] REG_TABLE [0:10] = '{
    16'h0F00, 16'h0004, 16'h1741, 16'h3102, 16'h3A17, 16'h3DA2,
    16'h3E6A, 16'h3FA0, 16'h0E80, 16'h5581, 16'h0E00
  };

  localparam int         NUM_REGS_DEF = $size(REG_TABLE);
  localparam logic [7:0] DEV_ADDR_DEF = 8'h40;

  // Three 9-bit frames; each ACK slot is a 1 so the master releases SDA there.
  function automatic logic [26:0] frame_word(input logic [7:0] dev, input logic [15:0] entry);
    return {dev, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/adv7180_config_i2c_byte_writer.sv
// Bit-period engine: owns the quarter-tick counter and the 27-bit shift word, and
// shapes SCL/SDA for whichever bus segment (START, BITS, STOP, GAP) the sequencer selects.
`timescale 1ns/1ps
module i2c_byte_writer
  import adv7180_cfg_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  state_t      seg,
  input  logic        start,
  input  logic [26:0] word,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_low,
  output logic        bit_end,
  output logic        ack_slot,
  output logic        done,
  output logic        nack
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [26:0]   shift;
  logic [4:0]    bit_cnt;
  logic          running;
  logic          q_last;

  assign running  = seg inside {ST_START, ST_BITS, ST_STOP, ST_GAP};
  assign q_last   = (qcnt == QW'(CLK_DIV - 1));
  assign bit_end  = running && q_last && (phase == 2'd3);
  assign ack_slot = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);
  assign done     = bit_end && (seg == ST_BITS) && (bit_cnt == 5'd26);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt    <= '0;
      phase   <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      nack    <= 1'b0;
    end else if (start) begin
      qcnt    <= '0;
      phase   <= '0;
      shift   <= word;
      bit_cnt <= '0;
      nack    <= 1'b0;
    end else if (running) begin
      qcnt <= q_last ? '0 : qcnt + 1'b1;
      if (q_last) phase <= phase + 2'd1;
      if (bit_end && (seg == ST_BITS)) begin
        shift   <= {shift[25:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      // Only a clean 0 is an ACK; z/x fall through to the NACK branch.
      if ((seg == ST_BITS) && ack_slot && (phase == 2'd3) && (qcnt == '0)) begin
        if (sda_in == 1'b0) nack <= 1'b0;
        else                nack <= 1'b1;
      end
    end else begin
      qcnt  <= '0;
      phase <= '0;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (seg)
      ST_START: sda_low = phase[1];
      ST_BITS: begin
        scl     = phase[1];
        sda_low = ~shift[26];
      end
      ST_STOP: begin
        scl     = phase[1];
        sda_low = (phase != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adv7180_config_top.sv
// ADV7180 power-up configuration master: one I2C write per table entry, then `finish`.
// Optional macro ADV7180_ACK_CHECK_EN: a NACK in any ACK slot retries the same entry.
`timescale 1ns/1ps
module adv7180_config_top
  import adv7180_cfg_pkg::*;
#(
  parameter int         CLK_DIV        = 125,
  parameter logic [7:0] DEV_ADDR       = DEV_ADDR_DEF,
  parameter int         NUM_REGS       = NUM_REGS_DEF,
  parameter int         STARTUP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic ADV7180_SCL,
  inout  wire  ADV7180_SDA,
  output logic finish
);

  localparam int IW = $clog2(NUM_REGS + 1);
  localparam int WW = $clog2(STARTUP_CYCLES + 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wait_cnt;
  logic          retry;
  logic          sda_low;
  logic          bit_end;
  logic          ack_slot;
  logic          bits_done;
  logic          nack;
  logic          nack_abort;
  logic          load;

  // Open-drain: only ever pull low or release.
  assign ADV7180_SDA = sda_low ? 1'b0 : 1'bz;
  assign load        = (state == ST_START) && bit_end;

`ifdef ADV7180_ACK_CHECK_EN
  assign nack_abort = bit_end && ack_slot && nack;
`else
  assign nack_abort = 1'b0;
  wire unused_nack = nack;
`endif

  i2c_byte_writer #(.CLK_DIV(CLK_DIV)) u_writer (
    .clk      (clk),
    .rst      (rst),
    .seg      (state),
    .start    (load),
    .word     (frame_word(DEV_ADDR, REG_TABLE[idx])),
    .sda_in   (ADV7180_SDA),
    .scl      (ADV7180_SCL),
    .sda_low  (sda_low),
    .bit_end  (bit_end),
    .ack_slot (ack_slot),
    .done     (bits_done),
    .nack     (nack)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT;
      idx      <= '0;
      wait_cnt <= '0;
      retry    <= 1'b0;
      finish   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == WW'(STARTUP_CYCLES - 1)) state <= ST_START;
          else                                     wait_cnt <= wait_cnt + 1'b1;
        end
        ST_START: if (bit_end) state <= ST_BITS;
        ST_BITS: begin
          if (nack_abort) begin
            state <= ST_STOP;
            retry <= 1'b1;
          end else if (bits_done) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: if (bit_end) state <= ST_GAP;
        ST_GAP: begin
          if (bit_end) begin
            if (retry) begin
              retry <= 1'b0;
              state <= ST_START;
            end else begin
              idx <= idx + 1'b1;
              if (idx == IW'(NUM_REGS - 1)) begin
                state  <= ST_DONE;
                finish <= 1'b1;
              end else begin
                state <= ST_START;
              end
            end
          end
        end
        default: finish <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_adv7180_config_top.sv
// Bench for adv7180_config_top: decodes the I2C bus, plays an ACKing slave, and
// compares against a byte-stream/timing model derived from the register list.
`timescale 1ns/1ps
module tb_adv7180_config_top;

  localparam int CLK_DIV = 4;
  localparam int STARTUP = 16;
  localparam int TX_CYC  = 120 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_low = 1'b0;
  logic scl;
  logic finish;
  wire  sda_bus;

  int total = 0;
  int bad   = 0;

  // Bench-side bus state written by the monitor process
  logic [7:0] got_bytes[$];
  int         tx_seen = 0;
  int         stops   = 0;

  logic [15:0] tbl [0:10] = '{16'h0F00, 16'h0004, 16'h1741, 16'h3102, 16'h3A17, 16'h3DA2,
                              16'h3E6A, 16'h3FA0, 16'h0E80, 16'h5581, 16'h0E00};

  pullup (sda_bus);
  assign sda_bus = (slave_low && !rst) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  adv7180_config_top #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ADV7180_SCL (scl),
    .ADV7180_SDA (sda_bus),
    .finish      (finish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and slave: decodes START/STOP/bytes, checks SCL-high width and
  // START/STOP placement, and ACKs every frame except the data frame of the 3rd write.
  initial begin
    logic prev_scl, prev_sda, sda_v, cur_scl, counting, in_tx;
    logic [7:0] cur;
    int bitcnt, high_len;
    prev_scl = 1'b1; prev_sda = 1'b1; counting = 1'b0; in_tx = 1'b0;
    cur = '0; bitcnt = 0; high_len = 0;
    forever begin
      @(negedge clk);
      sda_v   = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      cur_scl = scl;
      if (rst) begin
        in_tx = 1'b0; bitcnt = 0; counting = 1'b0; slave_low = 1'b0;
        tx_seen = 0; stops = 0; got_bytes.delete();
      end else begin
        if (prev_scl && cur_scl && (prev_sda != sda_v)) begin
          if (prev_sda) begin
            check("start_while_idle", {31'd0, in_tx}, 32'd0);
            in_tx = 1'b1; bitcnt = 0; tx_seen++;
          end else begin
            check("stop_after_27_bits", bitcnt, 27);
            in_tx = 1'b0; stops++;
          end
          counting = 1'b0;
        end else if (!prev_scl && cur_scl) begin
          if (in_tx && bitcnt < 27) begin
            if (bitcnt % 9 < 8) cur = {cur[6:0], sda_v};
            if (bitcnt % 9 == 7) got_bytes.push_back(cur);
            bitcnt++;
            counting = 1'b1; high_len = 1;
          end
        end else if (prev_scl && cur_scl && counting) begin
          high_len++;
        end else if (prev_scl && !cur_scl) begin
          if (counting) check("scl_high_len", high_len, 8);
          counting = 1'b0;
          if (in_tx && bitcnt % 9 == 8) slave_low = !(tx_seen == 3 && bitcnt == 26);
          else                          slave_low = 1'b0;
        end
      end
      prev_scl = cur_scl;
      prev_sda = sda_v;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for finish, then compares arrival time and the decoded stream to the model.
  task automatic run_and_check(input string tag);
    logic [7:0] exp_bytes[$];
    int entries[$];
    int c, lo, hi, exp_c, n, drops;
    for (int e = 0; e < 11; e++) begin
      entries.push_back(e);
`ifdef ADV7180_ACK_CHECK_EN
      if (e == 2) entries.push_back(e);
`endif
    end
    foreach (entries[k]) begin
      exp_bytes.push_back(8'h40);
      exp_bytes.push_back(tbl[entries[k]][15:8]);
      exp_bytes.push_back(tbl[entries[k]][7:0]);
    end
    exp_c = STARTUP + entries.size() * TX_CYC;
    lo = exp_c - 1; hi = exp_c + 2;
    c = 0;
    while (!finish && c < 9000) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("%s finish_time", tag), (c >= lo && c <= hi) ? exp_c : c, exp_c);
    check($sformatf("%s tx_count", tag), tx_seen, entries.size());
    check($sformatf("%s stop_count", tag), stops, entries.size());
    check($sformatf("%s byte_count", tag), got_bytes.size(), exp_bytes.size());
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
    drops = 0;
    repeat (100) begin
      @(negedge clk);
      if (finish !== 1'b1 || scl !== 1'b1 || sda_bus !== 1'b1) drops++;
    end
    check($sformatf("%s finish_sticky_bus_idle", tag), drops, 0);
  endtask

  initial begin
    int c;
    // Reset hold: bus idle (SDA reads 1 via the pull-up when released), finish low
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_scl", scl, 1);
      check("reset_sda", sda_bus, 1);
      check("reset_finish", finish, 0);
    end
    rst = 1'b0;
    run_and_check("run1");

    // Second run, reset asynchronously in the middle of the 3rd write
    rst = 1'b1;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (tx_seen < 3 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("reached_tx3", tx_seen, 3);
    repeat ($urandom_range(20, 400)) @(negedge clk);
    check("finish_low_mid_run", finish, 0);
    #1 rst = 1'b1;
    #1;
    check("async_abort_scl", scl, 1);
    check("async_abort_sda", sda_bus, 1);
    check("async_abort_finish", finish, 0);
    repeat ($urandom_range(3, 12)) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("finish_low_after_rerelease", finish, 0);
    run_and_check("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
